// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-control bundle between control unit/caches and the PC sequencer
interface pc_sequencer_if;
  logic        I_BUSYWAIT;
  logic        D_BUSYWAIT;
  logic        JUMP;
  logic        BRANCH_EQ;
  logic        BRANCH_NE;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] PC;
  logic        IREAD;
  logic        STALL;
  logic        TAKEN;

  modport master (
    output I_BUSYWAIT, D_BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET,
    input  PC, IREAD, STALL, TAKEN
  );

  modport slave (
    input  I_BUSYWAIT, D_BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET,
    output PC, IREAD, STALL, TAKEN
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with branch/jump redirect and cache-stall freeze
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           CLK,
  input  logic           RESET,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_take_q, pend_take_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        take;
  logic        busy;
  logic        iread;
  logic        stall;
  logic        taken;

  // PC is frozen across a stall, so PC+4 during HOLD equals the value at capture
  assign pc_plus4 = pc_q + 32'd4;
  assign target   = pc_plus4 + {{22{bus.OFFSET[7]}}, bus.OFFSET, 2'b00};
  assign take     = bus.JUMP | (bus.BRANCH_EQ & bus.ZERO) | (bus.BRANCH_NE & ~bus.ZERO);
  assign busy     = bus.I_BUSYWAIT | bus.D_BUSYWAIT;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_take_d   = pend_take_q;
    pend_target_d = pend_target_q;
    iread         = 1'b0;
    stall         = 1'b0;
    taken         = 1'b0;
    case (state_q)
      ST_BOOT: begin
        stall   = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        iread = 1'b1;
        stall = busy;
        taken = take;
        if (!busy) begin
          pc_d = take ? target : pc_plus4;
        end else begin
          pend_take_d   = take;
          pend_target_d = target;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        iread = 1'b1;
        stall = 1'b1;
        taken = pend_take_q;
        if (!busy) begin
          pc_d    = pend_take_q ? pend_target_q : pc_plus4;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pend_take_q   <= 1'b0;
      pend_target_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_take_q   <= pend_take_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.PC    = pc_q;
  assign bus.IREAD = iread;
  assign bus.STALL = stall;
  assign bus.TAKEN = taken;

endmodule
